// File: rtl/ucrn.sv
// ucrn: N-bit universal up/down counter with programmable wrap limit,
// optional saturation, a combinational terminal-count carry for cascading,
// and a sticky overflow flag. Bit 0 is the MSB on every vector port.
module ucrn #(
  parameter int               WIDTH    = 8,
  parameter bit               SATURATE = 1'b0,
  parameter logic [0:WIDTH-1] RESETVAL = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [0:WIDTH-1] D,
  input  logic [0:1]       SEL,
  input  logic             CIN,
  input  logic [0:WIDTH-1] LIMIT,
  output logic [0:WIDTH-1] Q,
  output logic             COUT,
  output logic             OVF
);

  typedef enum logic [1:0] {
    M_LOAD = 2'b00,
    M_DEC  = 2'b01,
    M_INC  = 2'b10,
    M_HOLD = 2'b11
  } mode_e;

  localparam logic [0:WIDTH-1] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  mode_e            mode;
  logic             at_lim;
  logic             at_zero;
  logic [0:WIDTH-1] q_nxt;
  logic             ovf_nxt;

  assign mode    = mode_e'(SEL);
  // Q above LIMIT (possible after a LOAD) is treated as terminal too.
  assign at_lim  = (Q >= LIMIT);
  assign at_zero = (Q == '0);

  // Next-state and lookahead carry; LIMIT is live, not registered.
  always_comb begin
    q_nxt   = Q;
    ovf_nxt = OVF;
    COUT    = 1'b0;
    case (mode)
      M_LOAD: begin
        q_nxt   = D;
        ovf_nxt = 1'b0;
        COUT    = 1'b1;
      end
      M_INC: begin
        COUT = CIN & at_lim;
        if (CIN) begin
          if (!at_lim) begin
            q_nxt = Q + ONE;
          end else begin
            ovf_nxt = 1'b1;
            q_nxt   = SATURATE ? LIMIT : '0;
          end
        end
      end
      M_DEC: begin
        COUT = CIN & at_zero;
        if (CIN) begin
          if (!at_zero) begin
            q_nxt = Q - ONE;
          end else begin
            ovf_nxt = 1'b1;
            q_nxt   = SATURATE ? '0 : LIMIT;
          end
        end
      end
      default: ;
    endcase
  end

  // Counter and sticky flag; reset beats every mode.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Q   <= RESETVAL;
      OVF <= 1'b0;
    end else begin
      Q   <= q_nxt;
      OVF <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_ucrn.sv
// tb_ucrn: directed vectors for wrap and saturate builds run side by side,
// plus a two-stage 4-bit cascade. Stimulus pushes hand-computed expectations
// into a queue; a monitor pops and compares on each falling edge.
module tb_ucrn;

  logic       clk = 1'b0;
  logic       RESET;
  logic [0:7] D, LIMIT;
  logic [0:1] SEL;
  logic       CIN;
  logic [0:7] q0, q1;
  logic       c0, c1, o0, o1;

  logic       crst;
  logic [0:1] csel;
  logic       ccin;
  logic [7:0] cd;
  logic [0:3] lq, hq;
  logic       lcout, hcout, lovf, hovf;

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  typedef struct {
    string      name;
    bit         casc;
    logic [7:0] q0, q1;
    logic       o0, o1, c0, c1;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  ucrn #(.WIDTH(8), .SATURATE(1'b0), .RESETVAL(8'd5)) u_wrap (
    .CLK(clk), .RESET(RESET), .D(D), .SEL(SEL), .CIN(CIN), .LIMIT(LIMIT),
    .Q(q0), .COUT(c0), .OVF(o0));

  ucrn #(.WIDTH(8), .SATURATE(1'b1), .RESETVAL(8'd5)) u_sat (
    .CLK(clk), .RESET(RESET), .D(D), .SEL(SEL), .CIN(CIN), .LIMIT(LIMIT),
    .Q(q1), .COUT(c1), .OVF(o1));

  ucrn #(.WIDTH(4), .SATURATE(1'b0), .RESETVAL(4'd0)) u_lo (
    .CLK(clk), .RESET(crst), .D(cd[3:0]), .SEL(csel), .CIN(ccin), .LIMIT(4'hF),
    .Q(lq), .COUT(lcout), .OVF(lovf));

  ucrn #(.WIDTH(4), .SATURATE(1'b0), .RESETVAL(4'd0)) u_hi (
    .CLK(clk), .RESET(crst), .D(cd[7:4]), .SEL(csel), .CIN(lcout), .LIMIT(4'hF),
    .Q(hq), .COUT(hcout), .OVF(hovf));

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%h want=%h", nm, fld, act, exp);
    end
  endtask

  // Row: inputs applied this cycle; expectations are the state entering the
  // cycle (result of the previous edge) and COUT for these inputs.
  task automatic cyc(input logic rst, input logic [1:0] sel, input logic cin,
                     input logic [7:0] d, input logic [7:0] lim,
                     input logic [7:0] eq0, input logic eo0, input logic ec0,
                     input logic [7:0] eq1, input logic eo1, input logic ec1,
                     input string nm);
    exp_t e;
    @(posedge clk); #1;
    RESET = rst; SEL = sel; CIN = cin; D = d; LIMIT = lim;
    e.name = nm; e.casc = 1'b0;
    e.q0 = eq0; e.o0 = eo0; e.c0 = ec0;
    e.q1 = eq1; e.o1 = eo1; e.c1 = ec1;
    sbq.push_back(e);
  endtask

  task automatic ccyc(input logic rst, input logic [1:0] sel, input logic cin,
                      input logic [7:0] d, input logic [7:0] eq, input logic eo,
                      input logic ec, input string nm);
    exp_t e;
    @(posedge clk); #1;
    crst = rst; csel = sel; ccin = cin; cd = d;
    e.name = nm; e.casc = 1'b1;
    e.q0 = eq; e.o0 = eo; e.c0 = ec;
    e.q1 = '0; e.o1 = 1'b0; e.c1 = 1'b0;
    sbq.push_back(e);
  endtask

  // Monitor: pops one expectation per falling edge, prints the summary.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (!e.casc) begin
          chk(e.name, "wrap_q",    q0, e.q0);
          chk(e.name, "wrap_ovf",  {7'd0, o0}, {7'd0, e.o0});
          chk(e.name, "wrap_cout", {7'd0, c0}, {7'd0, e.c0});
          chk(e.name, "sat_q",     q1, e.q1);
          chk(e.name, "sat_ovf",   {7'd0, o1}, {7'd0, e.o1});
          chk(e.name, "sat_cout",  {7'd0, c1}, {7'd0, e.c1});
        end else begin
          chk(e.name, "casc_q",    {hq, lq}, e.q0);
          chk(e.name, "casc_ovf",  {7'd0, hovf}, {7'd0, e.o0});
          chk(e.name, "casc_cout", {7'd0, hcout}, {7'd0, e.c0});
        end
      end else if (done) begin
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  // Stimulus. Arguments: rst sel cin d lim | wrap q ovf cout | sat q ovf cout
  initial begin
    RESET = 1'b1; SEL = 2'b10; CIN = 1'b1; D = 8'd0; LIMIT = 8'd9;
    crst = 1'b1; csel = 2'b11; ccin = 1'b0; cd = 8'd0;
    // first edge is the reset edge, with INC+CIN active
    cyc(0, 2'b10, 1, 8'd0,  8'd9,   8'd5,   0, 0,  8'd5,   0, 0, "reset");
    cyc(0, 2'b00, 0, 8'd7,  8'd9,   8'd6,   0, 1,  8'd6,   0, 1, "rel_inc");
    cyc(0, 2'b10, 1, 8'd0,  8'd9,   8'd7,   0, 0,  8'd7,   0, 0, "ld7");
    cyc(0, 2'b10, 1, 8'd0,  8'd9,   8'd8,   0, 0,  8'd8,   0, 0, "inc8");
    cyc(0, 2'b10, 1, 8'd0,  8'd9,   8'd9,   0, 1,  8'd9,   0, 1, "inc9_term");
    cyc(0, 2'b10, 1, 8'd0,  8'd9,   8'd0,   1, 0,  8'd9,   1, 1, "wrap_sat");
    cyc(0, 2'b11, 1, 8'd0,  8'd9,   8'd1,   1, 0,  8'd9,   1, 0, "hold1");
    cyc(0, 2'b11, 1, 8'd0,  8'd9,   8'd1,   1, 0,  8'd9,   1, 0, "hold2");
    cyc(0, 2'b11, 0, 8'd0,  8'd9,   8'd1,   1, 0,  8'd9,   1, 0, "hold3");
    cyc(0, 2'b11, 1, 8'd0,  8'd9,   8'd1,   1, 0,  8'd9,   1, 0, "hold4");
    cyc(0, 2'b11, 1, 8'd0,  8'd9,   8'd1,   1, 0,  8'd9,   1, 0, "hold5");
    cyc(0, 2'b00, 1, 8'd1,  8'd9,   8'd1,   1, 1,  8'd9,   1, 1, "hold_sticky");
    cyc(0, 2'b01, 1, 8'd0,  8'd9,   8'd1,   0, 0,  8'd1,   0, 0, "ld1_clr");
    cyc(0, 2'b01, 1, 8'd0,  8'd9,   8'd0,   0, 1,  8'd0,   0, 1, "dec0");
    cyc(0, 2'b01, 1, 8'd0,  8'd9,   8'd9,   1, 0,  8'd0,   1, 1, "dec_wrap");
    cyc(0, 2'b00, 0, 8'd3,  8'd9,   8'd8,   1, 1,  8'd0,   1, 1, "dec_more");
    cyc(0, 2'b10, 1, 8'd0,  8'd9,   8'd3,   0, 0,  8'd3,   0, 0, "ld3");
    cyc(0, 2'b10, 0, 8'd0,  8'd9,   8'd4,   0, 0,  8'd4,   0, 0, "en1");
    cyc(0, 2'b10, 1, 8'd0,  8'd9,   8'd4,   0, 0,  8'd4,   0, 0, "en0");
    cyc(0, 2'b00, 1, 8'd12, 8'd9,   8'd5,   0, 1,  8'd5,   0, 1, "en1b");
    cyc(0, 2'b10, 1, 8'd0,  8'd9,   8'd12,  0, 1,  8'd12,  0, 1, "ld12_above");
    cyc(0, 2'b10, 1, 8'd0,  8'd0,   8'd0,   1, 1,  8'd9,   1, 1, "above_term");
    cyc(1, 2'b10, 1, 8'd0,  8'd9,   8'd0,   1, 0,  8'd0,   1, 0, "live_limit0");
    cyc(0, 2'b00, 0, 8'd254,8'd255, 8'd5,   0, 1,  8'd5,   0, 1, "midreset");
    cyc(0, 2'b10, 1, 8'd0,  8'd255, 8'd254, 0, 0,  8'd254, 0, 0, "ld254");
    cyc(0, 2'b10, 1, 8'd0,  8'd255, 8'd255, 0, 1,  8'd255, 0, 1, "max");
    cyc(0, 2'b11, 0, 8'd0,  8'd255, 8'd0,   1, 0,  8'd255, 1, 0, "mod256");
    // cascade: rst sel cin d | {hi,lo} hi_ovf hi_cout
    ccyc(0, 2'b00, 0, 8'h0F, 8'h00, 0, 1, "c_rst_ld");
    ccyc(0, 2'b10, 1, 8'h00, 8'h0F, 0, 0, "c_0f");
    ccyc(0, 2'b00, 0, 8'hFF, 8'h10, 0, 1, "c_carry");
    ccyc(0, 2'b10, 1, 8'h00, 8'hFF, 0, 1, "c_ff");
    ccyc(0, 2'b11, 0, 8'h00, 8'h00, 1, 0, "c_wrap");
    ccyc(0, 2'b11, 1, 8'h00, 8'h00, 1, 0, "c_hold");
    done = 1'b1;
    repeat (20) @(posedge clk);
    $display("FAIL drain_timeout pending=%0d want=0", sbq.size());
    $fatal(1, "scoreboard did not drain");
  end

endmodule
